// File: rtl/pipe_pkg.sv
// pipe_pkg: shared MEM-stage types and constants
package pipe_pkg;
    localparam int XLEN_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } state_e;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_ctrl_t;

    localparam wb_ctrl_t BUBBLE_CTRL = '{memtoreg: 1'b0, regwrite: 1'b0};
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request/response bus
interface mem_access_unit_if #(
    parameter int XLEN = pipe_pkg::XLEN_DEF
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; bubble wins over load
module mem_wb_reg
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            bubble_i,
    input  logic            memtoreg_i,
    input  logic            regwrite_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] readdata_i,
    output logic            memtoreg_o,
    output logic            regwrite_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] readdata_o
);
    always_ff @(posedge clk) begin
        if (rst || bubble_i) begin
            {memtoreg_o, regwrite_o} <= rst ? 2'b00 : BUBBLE_CTRL;
            rd_o                     <= '0;
            alu_result_o             <= '0;
            readdata_o               <= '0;
        end else if (load_i) begin
            memtoreg_o   <= memtoreg_i;
            regwrite_o   <= regwrite_i;
            rd_o         <= rd_i;
            alu_result_o <= alu_result_i;
            readdata_o   <= readdata_i;
        end
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage issuing data-memory requests with stall, timeout abort and MEM/WB register
module mem_access_unit
    import pipe_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memtoreg_mem,
    input  logic              memread_mem,
    input  logic              memwrite_mem,
    input  logic              regwrite_mem,
    input  logic [XLEN-1:0]   alu_result_mem,
    input  logic [XLEN-1:0]   writedata_mem,
    input  logic [4:0]        rd_mem,
    input  logic [4:0]        RegRs2_mem,
    input  logic              fwd_regwrite,
    input  logic [4:0]        fwd_rd,
    input  logic [XLEN-1:0]   fwd_result,
    mem_access_unit_if.master dmem,
    output logic              stall_mem,
    output logic              wb_memtoreg,
    output logic              wb_regwrite,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_alu_result,
    output logic [XLEN-1:0]   wb_readdata,
    output logic              misalign_err,
    output logic              bus_err
);
    localparam int              CW   = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic            we_q;
    logic            mem_op, aligned, issue, done, fwd_hit, bubble;
    logic [XLEN-1:0] store_data;

    assign mem_op     = memread_mem | memwrite_mem;
    assign aligned    = alu_result_mem[2:0] == 3'b000;
    assign issue      = !rst && state_q == IDLE && mem_op && aligned;
    assign done       = state_q == WAIT && dmem.dmem_ready;
    assign fwd_hit    = fwd_regwrite && fwd_rd == RegRs2_mem && fwd_rd != 5'd0;
    assign store_data = fwd_hit ? fwd_result : writedata_mem;

    // In WAIT the bus is replayed from the holding registers so it stays stable
    assign dmem.dmem_req   = issue || (!rst && state_q == WAIT);
    assign dmem.dmem_we    = state_q == WAIT ? we_q : memwrite_mem;
    assign dmem.dmem_addr  = state_q == WAIT ? addr_q : alu_result_mem;
    assign dmem.dmem_wdata = state_q == WAIT ? wdata_q : store_data;

    assign stall_mem    = dmem.dmem_req && !done;
    assign misalign_err = !rst && state_q == IDLE && mem_op && !aligned;
    assign bus_err      = !rst && state_q == ABORT;
    assign bubble       = stall_mem || misalign_err || bus_err;

    always_comb begin
        state_d = issue ? WAIT
                : state_q == ABORT ? IDLE
                : state_q == WAIT ? (dmem.dmem_ready ? IDLE : cnt_q == LAST ? ABORT : WAIT)
                : state_q;
        // Saturates at LAST so the counter never wraps
        cnt_d   = issue ? '0
                : (state_q == WAIT && !dmem.dmem_ready && cnt_q != LAST) ? cnt_q + 1'b1
                : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue) begin
                addr_q  <= alu_result_mem;
                wdata_q <= store_data;
                we_q    <= memwrite_mem;
            end
        end
    end

    mem_wb_reg #(.XLEN(XLEN)) u_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .load_i       (!stall_mem),
        .bubble_i     (bubble),
        .memtoreg_i   (memtoreg_mem),
        .regwrite_i   (regwrite_mem),
        .rd_i         (rd_mem),
        .alu_result_i (alu_result_mem),
        .readdata_i   (done ? dmem.dmem_rdata : '0),
        .memtoreg_o   (wb_memtoreg),
        .regwrite_o   (wb_regwrite),
        .rd_o         (wb_rd),
        .alu_result_o (wb_alu_result),
        .readdata_o   (wb_readdata)
    );
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table, reset corner sequence and randomized ops against a transaction-level model
module tb_mem_access_unit;
    localparam int XLEN = 64;
    localparam int TO   = 16;

    typedef struct {
        logic            rd_op, wr_op, regwrite, memtoreg;
        logic [4:0]      rd, rs2, fwd_rd;
        logic            fwd_rw;
        logic [XLEN-1:0] addr, wdata, fwd_res, rdata;
        int              lat;
    } op_t;

    typedef struct {
        logic            req, we, mis, berr, wb_valid, wb_rw, wb_mtr;
        logic [4:0]      wb_rd;
        logic [XLEN-1:0] addr, wdata, wb_alu, wb_rdata;
        int              wait_cycles;
    } exp_t;

    typedef struct {
        op_t  o;
        exp_t e;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            memtoreg_mem, memread_mem, memwrite_mem, regwrite_mem;
    logic [XLEN-1:0] alu_result_mem, writedata_mem, fwd_result, wb_alu_result, wb_readdata;
    logic [4:0]      rd_mem, RegRs2_mem, fwd_rd, wb_rd;
    logic            fwd_regwrite, stall_mem, wb_memtoreg, wb_regwrite, misalign_err, bus_err;
    int              n_cmp = 0;
    int              n_fail = 0;
    vec_t            tbl[12];
    op_t             nop_op;
    op_t             rst_op;

    mem_access_unit_if #(.XLEN(XLEN)) dmem();

    mem_access_unit #(.XLEN(XLEN), .TIMEOUT_CYC(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .memtoreg_mem   (memtoreg_mem),
        .memread_mem    (memread_mem),
        .memwrite_mem   (memwrite_mem),
        .regwrite_mem   (regwrite_mem),
        .alu_result_mem (alu_result_mem),
        .writedata_mem  (writedata_mem),
        .rd_mem         (rd_mem),
        .RegRs2_mem     (RegRs2_mem),
        .fwd_regwrite   (fwd_regwrite),
        .fwd_rd         (fwd_rd),
        .fwd_result     (fwd_result),
        .dmem           (dmem),
        .stall_mem      (stall_mem),
        .wb_memtoreg    (wb_memtoreg),
        .wb_regwrite    (wb_regwrite),
        .wb_rd          (wb_rd),
        .wb_alu_result  (wb_alu_result),
        .wb_readdata    (wb_readdata),
        .misalign_err   (misalign_err),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: what one stage instruction must produce end to end
    function automatic exp_t model(input op_t o);
        exp_t e;
        logic fwd;
        e = '{default: 0};
        fwd = o.fwd_rw && o.fwd_rd == o.rs2 && o.fwd_rd != 5'd0;
        e.addr = o.addr;
        e.wb_rd = o.rd;
        e.wb_alu = o.addr;
        e.wb_rdata = o.rdata;
        if (!(o.rd_op || o.wr_op)) begin
            e.wb_valid = 1'b1;
            e.wb_rw = o.regwrite;
            e.wb_mtr = o.memtoreg;
        end else if (o.addr % 8 != 0) begin
            e.mis = 1'b1;
        end else begin
            e.req = 1'b1;
            e.we = o.wr_op;
            e.wdata = fwd ? o.fwd_res : o.wdata;
            if (o.lat >= TO) begin
                e.berr = 1'b1;
                e.wait_cycles = TO;
            end else begin
                e.wait_cycles = o.lat + 1;
                e.wb_valid = 1'b1;
                e.wb_rw = o.regwrite;
                e.wb_mtr = o.memtoreg;
            end
        end
        return e;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int k;
        k = int'($urandom_range(0, 9));
        o.rd_op = k < 4 || k == 8;
        o.wr_op = (k >= 4 && k < 7) || k == 8;
        o.regwrite = 1'($urandom);
        o.memtoreg = 1'($urandom);
        o.rd = 5'($urandom);
        o.rs2 = 5'($urandom_range(0, 3));
        o.fwd_rd = 5'($urandom_range(0, 3));
        o.fwd_rw = 1'($urandom);
        o.addr = {$urandom, $urandom};
        if ($urandom_range(0, 4) != 0) o.addr[2:0] = 3'b000;
        o.wdata = {$urandom, $urandom};
        o.fwd_res = {$urandom, $urandom};
        o.rdata = {$urandom, $urandom};
        o.lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO + 3)) : int'($urandom_range(0, 4));
        return o;
    endfunction

    task automatic drive(input op_t o);
        memread_mem = o.rd_op;
        memwrite_mem = o.wr_op;
        regwrite_mem = o.regwrite;
        memtoreg_mem = o.memtoreg;
        rd_mem = o.rd;
        RegRs2_mem = o.rs2;
        fwd_rd = o.fwd_rd;
        fwd_regwrite = o.fwd_rw;
        alu_result_mem = o.addr;
        writedata_mem = o.wdata;
        fwd_result = o.fwd_res;
        dmem.dmem_rdata = o.rdata;
    endtask

    task automatic chk_bus(input exp_t e, input logic stall_exp);
        chk1("dmem_req", dmem.dmem_req, 1'b1);
        chk1("stall_mem", stall_mem, stall_exp);
        chk("dmem_addr", dmem.dmem_addr, e.addr);
        chk1("dmem_we", dmem.dmem_we, e.we);
        if (e.we) chk("dmem_wdata", dmem.dmem_wdata, e.wdata);
        chk1("misalign_err", misalign_err, 1'b0);
        chk1("bus_err", bus_err, 1'b0);
    endtask

    task automatic chk_wb(input exp_t e, input logic bubble);
        chk1("wb_regwrite", wb_regwrite, bubble ? 1'b0 : e.wb_rw);
        chk1("wb_memtoreg", wb_memtoreg, bubble ? 1'b0 : e.wb_mtr);
        if (!bubble) begin
            chk("wb_rd", 64'(wb_rd), 64'(e.wb_rd));
            chk("wb_alu_result", wb_alu_result, e.wb_alu);
            if (e.req) chk("wb_readdata", wb_readdata, e.wb_rdata);
        end
    endtask

    task automatic run(input op_t o, input exp_t e);
        logic last;
        @(negedge clk);
        drive(o);
        dmem.dmem_ready = 1'($urandom);
        #1;
        if (e.req) chk_bus(e, 1'b1);
        else begin
            chk1("dmem_req", dmem.dmem_req, 1'b0);
            chk1("stall_mem", stall_mem, 1'b0);
            chk1("misalign_err", misalign_err, e.mis);
            chk1("bus_err", bus_err, 1'b0);
        end
        @(posedge clk);
        #1;
        if (!e.req) begin
            chk_wb(e, !e.wb_valid);
            return;
        end
        chk_wb(e, 1'b1);
        for (int c = 0; c < e.wait_cycles; c++) begin
            last = c == e.wait_cycles - 1;
            @(negedge clk);
            dmem.dmem_ready = last && !e.berr;
            alu_result_mem = last ? o.addr : {$urandom, $urandom};
            writedata_mem = last ? o.wdata : {$urandom, $urandom};
            fwd_result = last ? o.fwd_res : {$urandom, $urandom};
            #1;
            chk_bus(e, !(last && !e.berr));
            @(posedge clk);
            #1;
            chk_wb(e, !(last && e.wb_valid));
        end
        if (e.berr) begin
            @(negedge clk);
            dmem.dmem_ready = 1'($urandom);
            #1;
            chk1("abort dmem_req", dmem.dmem_req, 1'b0);
            chk1("abort bus_err", bus_err, 1'b1);
            chk1("abort stall_mem", stall_mem, 1'b0);
            chk1("abort misalign_err", misalign_err, 1'b0);
            @(posedge clk);
            #1;
            chk_wb(e, 1'b1);
        end
    endtask

    initial begin
        nop_op = '{default: 0};
        //            rd_op wr_op rw    mtr   rd     rs2    frd    frw   addr          wdata     fres      rdata            lat
        tbl[0].o  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd5,  5'd0,  5'd0,  1'b0, 64'h1234, 64'h0,  64'h0,  64'h0,        0};
        tbl[1].o  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  5'd0,  5'd0,  1'b0, 64'h100,  64'h0,  64'h0,  64'hDEADBEEF, 3};
        tbl[2].o  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd7,  5'd7,  1'b1, 64'h200,  64'h55, 64'hAA, 64'h0,        0};
        tbl[3].o  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 64'h208,  64'h55, 64'hAA, 64'h0,        0};
        tbl[4].o  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd7,  5'd7,  1'b0, 64'h210,  64'h55, 64'hAA, 64'h0,        2};
        tbl[5].o  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd4,  5'd0,  5'd0,  1'b0, 64'h300,  64'h0,  64'h0,  64'h77,       30};
        tbl[6].o  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd6,  5'd0,  5'd0,  1'b0, 64'h104,  64'h0,  64'h0,  64'h0,        0};
        tbl[7].o  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  5'd2,  5'd3,  1'b1, 64'h8,    64'h99, 64'h11, 64'h0,        1};
        tbl[8].o  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  5'd0,  5'd0,  1'b0, 64'h7,    64'h0,  64'h0,  64'h0,        0};
        tbl[9].o  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd1,  5'd0,  1'b0, 64'h3,    64'h5,  64'h0,  64'h0,        0};
        tbl[10].o = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 5'd0,  5'd0,  1'b0, 64'h400,  64'h0,  64'h0,  64'h1111,     15};
        tbl[11].o = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 5'd0,  5'd0,  1'b0, 64'h408,  64'h0,  64'h0,  64'h2222,     16};
        //            req   we    mis   berr  valid rw    mtr   rd     addr      wdata     alu       rdata            wait
        tbl[0].e  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5,  64'h1234, 64'h0,  64'h1234, 64'h0,        0};
        tbl[1].e  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3,  64'h100,  64'h0,  64'h100,  64'hDEADBEEF, 4};
        tbl[2].e  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  64'h200,  64'hAA, 64'h200,  64'h0,        1};
        tbl[3].e  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  64'h208,  64'h55, 64'h208,  64'h0,        1};
        tbl[4].e  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  64'h210,  64'h55, 64'h210,  64'h0,        3};
        tbl[5].e  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  64'h300,  64'h0,  64'h0,    64'h0,        16};
        tbl[6].e  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  64'h0,    64'h0,  64'h0,    64'h0,        0};
        tbl[7].e  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  64'h8,    64'h99, 64'h8,    64'h0,        2};
        tbl[8].e  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9,  64'h7,    64'h0,  64'h7,    64'h0,        0};
        tbl[9].e  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  64'h0,    64'h0,  64'h0,    64'h0,        0};
        tbl[10].e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 64'h400,  64'h0,  64'h400,  64'h1111,     16};
        tbl[11].e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  64'h408,  64'h0,  64'h0,    64'h0,        16};

        drive(nop_op);
        dmem.dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset wb_regwrite", wb_regwrite, 1'b0);
        chk1("reset wb_memtoreg", wb_memtoreg, 1'b0);
        chk("reset wb_rd", 64'(wb_rd), 64'h0);
        chk("reset wb_alu_result", wb_alu_result, 64'h0);
        chk("reset wb_readdata", wb_readdata, 64'h0);
        chk1("reset dmem_req", dmem.dmem_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run(tbl[i].o, tbl[i].e);

        // Reset arriving on the second WAIT cycle abandons the access silently
        rst_op = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 64'h500, 64'h0, 64'h0, 64'h3333, 40};
        @(negedge clk);
        drive(rst_op);
        dmem.dmem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk1("wait1 dmem_req", dmem.dmem_req, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(nop_op);
        @(posedge clk);
        #1;
        chk1("rst-wait dmem_req", dmem.dmem_req, 1'b0);
        chk1("rst-wait bus_err", bus_err, 1'b0);
        chk1("rst-wait stall_mem", stall_mem, 1'b0);
        chk1("rst-wait wb_regwrite", wb_regwrite, 1'b0);
        chk1("rst-wait wb_memtoreg", wb_memtoreg, 1'b0);
        chk("rst-wait wb_rd", 64'(wb_rd), 64'h0);
        chk("rst-wait wb_alu_result", wb_alu_result, 64'h0);
        chk("rst-wait wb_readdata", wb_readdata, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            chk1("post-rst bus_err", bus_err, 1'b0);
            chk1("post-rst dmem_req", dmem.dmem_req, 1'b0);
        end
        run(tbl[0].o, tbl[0].e);

        for (int i = 0; i < 200; i++) begin
            op_t o;
            o = rand_op();
            run(o, model(o));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data/address width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16, meaning the maximum number of WAIT cycles before abort.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 memtoreg_mem, memread_mem, memwrite_mem, regwrite_mem  in  1 each  control bits from EX/MEM register.
REQ-006 alu_result_mem  in  XLEN  address or ALU result; writedata_mem  in  XLEN  store data.
REQ-007 rd_mem  in  5  destination register; RegRs2_mem  in  5  store-source register.
REQ-008 fwd_regwrite  in  1,  fwd_rd  in  5,  fwd_result  in  XLEN  write-back forwarding source.
REQ-009 dmem_req  out  1,  dmem_we  out  1,  dmem_addr  out  XLEN,  dmem_wdata  out  XLEN  request to data memory.
REQ-010 dmem_ready  in  1,  dmem_rdata  in  XLEN  memory response.
REQ-011 stall_mem  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-012 wb_memtoreg, wb_regwrite  out  1;  wb_rd  out  5;  wb_alu_result, wb_readdata  out  XLEN  MEM/WB register.
REQ-013 misalign_err, bus_err  out  1  single-cycle error pulses.

Function
REQ-014 Memory op SHALL mean memread_mem or memwrite_mem high; both high SHALL be treated as a store.
REQ-015 FSM states SHALL be IDLE, WAIT, ABORT.
REQ-016 IDLE with no memory op: stall_mem=0, dmem_req=0; MEM/WB SHALL load stage inputs at next edge (latency 1).
REQ-017 IDLE with memory op and alu_result_mem[2:0]==0: dmem_req=1, stall_mem=1, addr/we/wdata driven from inputs and captured into holding registers; next state WAIT; counter cleared.
REQ-018 IDLE with memory op and alu_result_mem[2:0]!=0: no request; misalign_err=1 for that cycle; stall_mem=0; MEM/WB SHALL load a bubble (wb_regwrite=0, wb_memtoreg=0).
REQ-019 Store data SHALL be fwd_result when fwd_regwrite=1, fwd_rd==RegRs2_mem and fwd_rd!=0; otherwise writedata_mem.
REQ-020 WAIT: dmem_req=1, dmem_addr/dmem_we/dmem_wdata SHALL be held stable from the holding registers until dmem_ready is sampled high.
REQ-021 WAIT with dmem_ready=1: stall_mem=0 in that same cycle; MEM/WB SHALL load stage controls, wb_readdata=dmem_rdata; next state IDLE.
REQ-022 WAIT with dmem_ready=0: stall_mem=1; counter increments; on counter==TIMEOUT_CYC-1, next state ABORT.
REQ-023 ABORT (one cycle): dmem_req=0, bus_err=1, stall_mem=0, MEM/WB SHALL load a bubble; next state IDLE.
REQ-024 While stall_mem=1, MEM/WB SHALL load a bubble each edge (wb_regwrite=0, wb_memtoreg=0).
REQ-025 dmem_ready while in IDLE or ABORT SHALL be ignored.
REQ-026 Minimum memory-op latency SHALL be 2 cycles (IDLE issue + WAIT with ready).
REQ-027 Counter width SHALL be $clog2(TIMEOUT_CYC)+1 bits; it SHALL NOT wrap.

Reset
REQ-028 rst=1 at an edge SHALL force state IDLE, counter 0, holding registers 0, all MEM/WB outputs 0.
REQ-029 Reset in WAIT SHALL drop dmem_req after that edge; the in-flight access is abandoned without error pulse.
REQ-030 Reset SHALL take priority over every other transition.

Structure
REQ-031 State enum, XLEN default and bubble constant SHALL reside in a shared package pipe_pkg.
REQ-032 MEM/WB register SHALL be a sub-module mem_wb_reg with load and bubble controls.

Verification
REQ-033 ALU op: regwrite=1, rd=5, alu_result=0x1234 -> next cycle wb_rd=5, wb_alu_result=0x1234, wb_regwrite=1, stall_mem never 1.
REQ-034 Load at 0x100, dmem_ready after 3 low WAIT cycles, rdata=0xDEADBEEF -> dmem_req high 5 cycles with addr constant 0x100, stall_mem high 4 cycles, then wb_readdata=0xDEADBEEF, wb_memtoreg=1.
REQ-035 Store RegRs2_mem=7, fwd_regwrite=1, fwd_rd=7, fwd_result=0xAA, writedata_mem=0x55 -> dmem_we=1, dmem_wdata=0xAA; with fwd_rd=0 -> 0x55.
REQ-036 Load, dmem_ready held 0 -> dmem_req drops after 16 WAIT cycles, bus_err one-cycle pulse, wb_regwrite=0.
REQ-037 Load at 0x104 -> no dmem_req, misalign_err one-cycle pulse, stall_mem=0, wb_regwrite=0.
REQ-038 rst asserted on 2nd WAIT cycle -> dmem_req=0 next cycle, state IDLE, all outputs 0, no bus_err.
